sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Two-master to one-slave arbiter for the sram-like memory protocol.
- Shares a single memory port between the pipeline's instruction-fetch requester and its load/store requester.
- Allows at most one transaction in flight; serialises address and data phases; routes the response back to the owning master.
- Sits between the pipeline datapath and the cache/AXI bridge.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request is pending; the next grant is then forced to inst. Range 1..15.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- inst_req  in  1  inst master request
- inst_wr  in  1  inst write enable (always 0 in practice; forwarded anyway)
- inst_size  in  2  inst access size
- inst_addr  in  32  inst address
- inst_wdata  in  32  inst write data
- inst_addr_ok  out  1  inst request accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req  in  1  data master request
- data_wr  in  1  data write enable
- data_size  in  2  data access size
- data_addr  in  32  data address
- data_wdata  in  32  data write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- m_req  out  1  slave request
- m_wr  out  1  slave write enable
- m_size  out  2  slave access size
- m_addr  out  32  slave address
- m_wdata  out  32  slave write data
- m_addr_ok  in  1  slave accepted request
- m_data_ok  in  1  slave response valid
- m_rdata  in  32  slave read data
- busy  out  1  transaction in progress (state != IDLE)
- grant_data  out  1  registered owner of the current transaction: 1 = data, 0 = inst

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE, grant_data = 0, starve_cnt = 0, latched request fields = 0.
  - All outputs 0, including m_req and every ok pulse.
- States: IDLE, ADDR, DATA.
- IDLE, arbitration (combinational within the cycle):
  - Winner = data if data_req and not (inst_req and starve_cnt == STARVE_LIMIT); else inst if inst_req; else none.
  - Winner's *_addr_ok = 1 this cycle, a one-cycle pulse; the loser's addr_ok = 0.
  - At posedge: latch the winner's wr/size/addr/wdata, set grant_data, go to ADDR.
  - m_req = 0 in IDLE.
- starve_cnt update, at each IDLE grant:
  - Data granted while inst_req = 1: increment, saturating at STARVE_LIMIT.
  - Inst granted, or inst_req = 0: clear.
- ADDR:
  - m_req = 1; m_wr/m_size/m_addr/m_wdata driven from latches.
  - Hold until m_addr_ok; then go to DATA.
  - m_addr_ok and m_data_ok high in the same cycle counts as completion: route the response and go to IDLE.
- DATA:
  - m_req = 0; wait for m_data_ok.
  - On m_data_ok: granted master's *_data_ok = 1 for that cycle with *_rdata = m_rdata (combinational); go to IDLE.
- Response routing:
  - The non-owner's data_ok is always 0.
  - *_rdata outputs are 0 when their data_ok is 0.
- Latency:
  - Minimum 3 cycles from an IDLE grant to data_ok (IDLE, ADDR with addr_ok, DATA with data_ok); 2 cycles when addr_ok and data_ok coincide.
  - A new grant is possible in the cycle after data_ok.
- Masters must drop req after their addr_ok pulse; a req still held in IDLE is treated as a new request.
- m_data_ok or m_addr_ok in IDLE is ignored and produces no master pulse. This covers stale responses after reset mid-transaction: the transaction is abandoned, no data_ok is delivered, and the masters must reissue.
- Writes complete with data_ok exactly like reads; rdata is passed through unchanged.

Test Plan:
1. Single inst read: inst_req=1, addr=0xBFC00000; slave addr_ok in cycle 1 of ADDR, data_ok 2 cycles later with rdata=0x3C010001 -> inst_addr_ok pulses in IDLE; m_addr=0xBFC00000, m_wr=0; inst_data_ok 1 cycle with inst_rdata=0x3C010001; data_data_ok stays 0.
2. Simultaneous requests: inst_req and data_req both high, data_wr=1, data_addr=0x80001000, wdata=0xDEADBEEF -> data wins; m_wr=1, m_wdata=0xDEADBEEF; inst wins the next IDLE cycle after data_data_ok.
3. Starvation, STARVE_LIMIT=4: inst_req held high, data_req reissued continuously -> exactly 4 data grants, then an inst grant, then starve_cnt=0.
4. Slave back-pressure: m_addr_ok held 0 for 5 cycles -> m_req and m_addr stable for all 5 cycles even if the master changes its inputs; no second grant.
5. Coincident ok: m_addr_ok and m_data_ok high in the same ADDR cycle -> owner data_ok that cycle; state back to IDLE next cycle; busy goes 0.
6. Reset mid-DATA: rstn low for 1 cycle in DATA, then slave returns m_data_ok -> no master data_ok; busy=0; outputs 0; a fresh inst request is then served normally.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master (inst / data) to one-slave arbiter for the sram-like protocol.
// One transaction in flight; data has priority unless inst has waited STARVE_LIMIT grants.
module sram_like_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        grant_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       idle;
  logic       starved;
  logic       pick_data;
  logic       pick_inst;
  logic       resp_fire;

  // Arbitration is only visible in IDLE and never while reset is asserted.
  assign idle      = rstn && (state == IDLE);
  assign starved   = inst_req && (starve_cnt == LIMIT);
  assign pick_data = idle && data_req && !starved;
  assign pick_inst = idle && inst_req && !pick_data;

  assign inst_addr_ok = pick_inst;
  assign data_addr_ok = pick_data;

  // A response in IDLE is stale (e.g. after a mid-transaction reset) and is dropped.
  assign resp_fire = m_data_ok && (((state == ADDR) && m_addr_ok) || (state == DATA));

  assign inst_data_ok = resp_fire && !grant_data;
  assign data_data_ok = resp_fire && grant_data;
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      grant_data <= 1'b0;
      busy       <= 1'b0;
      m_req      <= 1'b0;
      m_wr       <= 1'b0;
      m_size     <= 2'd0;
      m_addr     <= 32'h0;
      m_wdata    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_data || pick_inst) begin
            state      <= ADDR;
            busy       <= 1'b1;
            m_req      <= 1'b1;
            grant_data <= pick_data;
            m_wr       <= pick_data ? data_wr    : inst_wr;
            m_size     <= pick_data ? data_size  : inst_size;
            m_addr     <= pick_data ? data_addr  : inst_addr;
            m_wdata    <= pick_data ? data_wdata : inst_wdata;
            if (pick_data && inst_req)
              starve_cnt <= (starve_cnt == LIMIT) ? LIMIT : starve_cnt + 4'd1;
            else
              starve_cnt <= 4'd0;
          end
        end
        ADDR: begin
          if (m_addr_ok) begin
            m_req <= 1'b0;
            if (m_data_ok) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (m_data_ok) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: transaction-level model feeds expectation
// queues; a separate monitor pops and compares whenever the DUT shows a handshake.
module tb_sram_like_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd0;
  logic [31:0] inst_addr = 32'h0, inst_wdata = 32'h0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        busy, grant_data;

  sram_like_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .grant_data(grant_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } resp_t;

  req_t  slv_q[$];
  resp_t resp_q[$];
  bit    grant_q[$];
  bit    glog[$];
  bit    log_en = 1'b0;

  int tests = 0;
  int fails = 0;

  // model view of the current cycle
  bit m_free = 1'b1, m_in_addr = 1'b0, cur_owner = 1'b0;
  int m_starve = 0;
  bit exp_busy_now = 1'b0, exp_mreq_now = 1'b0, rst_now = 1'b1;
  bit inst_aok_s = 1'b0, data_aok_s = 1'b0;

  // stimulus knobs
  int p_inst = 0, p_data = 0, p_aok = 50, p_dok = 50;
  bit fix_inst = 1'b0, fix_data = 1'b0, fix_rdata = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works only from bench-driven inputs.
  always @(negedge clk) begin
    inst_aok_s = inst_addr_ok;
    data_aok_s = data_addr_ok;
    if (!rstn) begin
      rst_now = 1'b1;
      m_free = 1'b1; m_in_addr = 1'b0; m_starve = 0;
      exp_busy_now = 1'b0; exp_mreq_now = 1'b0;
      slv_q.delete(); resp_q.delete(); grant_q.delete();
    end else begin
      rst_now = 1'b0;
      exp_busy_now = !m_free;
      exp_mreq_now = !m_free && m_in_addr;
      if (m_free) begin
        if (inst_req || data_req) begin
          bit win_data;
          req_t r;
          win_data = data_req && !(inst_req && m_starve == L);
          grant_q.push_back(win_data);
          if (win_data) r = '{1'b1, data_wr, data_size, data_addr, data_wdata};
          else          r = '{1'b0, inst_wr, inst_size, inst_addr, inst_wdata};
          slv_q.push_back(r);
          if (win_data && inst_req) m_starve = (m_starve < L) ? m_starve + 1 : L;
          else                      m_starve = 0;
          cur_owner = win_data;
          m_free = 1'b0;
          m_in_addr = 1'b1;
        end
      end else if (m_in_addr) begin
        if (m_addr_ok) begin
          if (m_data_ok) begin
            resp_q.push_back('{cur_owner, m_rdata});
            m_free = 1'b1;
          end
          m_in_addr = 1'b0;
        end
      end else if (m_data_ok) begin
        resp_q.push_back('{cur_owner, m_rdata});
        m_free = 1'b1;
      end
    end
  end

  // Monitor: compares DUT outputs against the queues the model filled this cycle.
  always @(negedge clk) begin
    #1;
    if (rst_now) begin
      chk("reset_ctrl", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                         m_req, m_wr, m_size, busy, grant_data}, 64'h0);
      chk("reset_bus", {m_addr, m_wdata}, 64'h0);
      chk("reset_rdata", {inst_rdata, data_rdata}, 64'h0);
    end else begin
      chk("busy", busy, exp_busy_now);
      chk("m_req", m_req, exp_mreq_now);
      chk("addr_ok_onehot", inst_addr_ok & data_addr_ok, 0);
      if (inst_addr_ok || data_addr_ok) begin
        chk("grant_expected", grant_q.size() != 0, 1);
        if (grant_q.size() != 0) chk("grant_owner", data_addr_ok, grant_q.pop_front());
        if (log_en) glog.push_back(data_addr_ok);
      end
      chk("grant_missing", grant_q.size(), 0);
      grant_q.delete();
      if (exp_mreq_now && slv_q.size() != 0) begin
        chk("m_addr", m_addr, slv_q[0].addr);
        chk("m_wr", m_wr, slv_q[0].wr);
        chk("m_size", m_size, slv_q[0].size);
        chk("m_wdata", m_wdata, slv_q[0].wdata);
        chk("grant_data", grant_data, slv_q[0].owner);
        if (m_addr_ok) void'(slv_q.pop_front());
      end
      chk("data_ok_onehot", inst_data_ok & data_data_ok, 0);
      if (inst_data_ok || data_data_ok) begin
        chk("resp_expected", resp_q.size() != 0, 1);
        if (resp_q.size() != 0) begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_owner", data_data_ok, e.owner);
          chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
        end
      end
      chk("resp_missing", resp_q.size(), 0);
      resp_q.delete();
      if (!inst_data_ok) chk("inst_rdata_zero", inst_rdata, 0);
      if (!data_data_ok) chk("data_rdata_zero", data_rdata, 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    if (!inst_req || inst_aok_s) begin
      inst_req   = ($urandom_range(0, 99) < p_inst);
      inst_wr    = 1'b0;
      inst_size  = fix_inst ? 2'd2 : 2'($urandom_range(0, 3));
      inst_addr  = fix_inst ? 32'hBFC0_0000 : $urandom;
      inst_wdata = $urandom;
    end else if ($urandom_range(0, 99) < 30) begin
      inst_addr = fix_inst ? 32'hBFC0_0000 : $urandom;
    end
    if (!data_req || data_aok_s) begin
      data_req   = ($urandom_range(0, 99) < p_data);
      data_wr    = fix_data ? 1'b1 : 1'($urandom_range(0, 1));
      data_size  = fix_data ? 2'd2 : 2'($urandom_range(0, 3));
      data_addr  = fix_data ? 32'h8000_1000 : $urandom;
      data_wdata = fix_data ? 32'hDEAD_BEEF : $urandom;
    end else if ($urandom_range(0, 99) < 30) begin
      data_wdata = $urandom;
    end
    m_addr_ok = ($urandom_range(0, 99) < p_aok);
    m_data_ok = ($urandom_range(0, 99) < p_dok);
    m_rdata   = fix_rdata ? 32'h3C01_0001 : $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // single inst read at the boot vector
    fix_inst = 1'b1; fix_rdata = 1'b1;
    p_inst = 100; p_data = 0; p_aok = 60; p_dok = 60;
    step();
    p_inst = 0;
    repeat (15) step();
    fix_inst = 1'b0; fix_rdata = 1'b0;

    // simultaneous requests: data write wins
    fix_data = 1'b1;
    p_inst = 100; p_data = 100;
    step();
    p_inst = 0; p_data = 0;
    repeat (20) step();
    fix_data = 1'b0;

    // starvation pattern with both masters always requesting
    do_reset();
    p_inst = 100; p_data = 100; p_aok = 100; p_dok = 100;
    log_en = 1'b1;
    repeat (30) step();
    log_en = 1'b0;
    chk("starve_log_len", glog.size() >= 2 * (L + 1), 1);
    for (int k = 0; k < 2 * (L + 1) && k < glog.size(); k++)
      chk("starve_seq", glog[k], ((k % (L + 1)) == L) ? 0 : 1);

    // slave back-pressure while masters keep changing their inputs
    p_aok = 0; p_dok = 30;
    repeat (8) step();
    p_aok = 100;
    repeat (6) step();

    // coincident addr_ok/data_ok
    p_aok = 100; p_dok = 100;
    repeat (10) step();

    // reset while in the data phase, then a stale data_ok
    begin
      bit found;
      found = 1'b0;
      p_inst = 100; p_data = 0; p_aok = 100; p_dok = 0;
      for (int i = 0; i < 50 && !found; i++) begin
        step();
        if (!m_free && !m_in_addr) found = 1'b1;
      end
      chk("reach_data_phase", found, 1);
      rstn = 1'b0;
      m_data_ok = 1'b1;
      @(posedge clk); #1;
      rstn = 1'b1;
      p_inst = 0; p_dok = 100;
      repeat (5) step();
      fix_inst = 1'b1;
      p_inst = 100; p_dok = 50;
      step();
      p_inst = 0;
      repeat (12) step();
      fix_inst = 1'b0;
    end

    // long random run
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        p_inst = $urandom_range(0, 100);
        p_data = $urandom_range(0, 100);
        p_aok  = $urandom_range(10, 100);
        p_dok  = $urandom_range(10, 100);
      end
      if (i % 1000 == 999) do_reset();
      else step();
    end

    // drain
    p_inst = 0; p_data = 0; p_aok = 100; p_dok = 100;
    repeat (10) step();
    chk("drain_idle", busy, 0);
    chk("drain_slv_q", slv_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
